// File: rtl/kfmmc_pkg.sv
// Shared types and frame sizes for the KFMMC command sequencer.
package kfmmc_pkg;

    typedef enum logic [1:0] {
        NONE        = 2'd0,
        SHORT       = 2'd1,
        LONG        = 2'd2,
        SHORT_NOCRC = 2'd3
    } response_type_t;

    typedef enum logic [1:0] {
        OK        = 2'd0,
        TIMEOUT   = 2'd1,
        CRC_ERR   = 2'd2,
        FRAME_ERR = 2'd3
    } cmd_status_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX_LOAD,
        S_TX_WAIT,
        S_RX_ARM,
        S_RX_WAIT,
        S_CHECK,
        S_DONE
    } seq_state_t;

    localparam int SHORT_BYTES = 6;
    localparam int LONG_BYTES  = 17;

    // Index of the final response byte for a given response type.
    function automatic logic [4:0] last_rx_index(input response_type_t t);
        return (t == LONG) ? 5'(LONG_BYTES - 1) : 5'(SHORT_BYTES - 1);
    endfunction

endpackage

// File: rtl/kfmmc_command_sequencer_if.sv
// Host-side command handshake plus the command-side controls of the bit interface.
interface kfmmc_command_sequencer_if;
    import kfmmc_pkg::*;

    logic           cmd_start;
    logic [5:0]     cmd_index;
    logic [31:0]    cmd_argument;
    logic [1:0]     response_type;
    logic           cmd_busy;
    logic           cmd_done;
    cmd_status_t    cmd_status;
    logic [5:0]     response_index;
    logic [127:0]   response_data;

    logic           if_start_communication;
    logic           if_command_io;
    logic           if_check_command_start_bit;
    logic           if_clear_command_crc;
    logic           if_set_send_command;
    logic [7:0]     if_send_command;
    logic [7:0]     if_received_response;
    logic [6:0]     if_send_command_crc;
    logic [6:0]     if_received_response_crc;
    logic           if_sent_command_interrupt;
    logic           if_received_response_interrupt;
    logic           if_timeout_interrupt;

    modport slave (
        input  cmd_start, cmd_index, cmd_argument, response_type,
               if_received_response, if_send_command_crc, if_received_response_crc,
               if_sent_command_interrupt, if_received_response_interrupt, if_timeout_interrupt,
        output cmd_busy, cmd_done, cmd_status, response_index, response_data,
               if_start_communication, if_command_io, if_check_command_start_bit,
               if_clear_command_crc, if_set_send_command, if_send_command
    );

    modport master (
        output cmd_start, cmd_index, cmd_argument, response_type,
               if_received_response, if_send_command_crc, if_received_response_crc,
               if_sent_command_interrupt, if_received_response_interrupt, if_timeout_interrupt,
        input  cmd_busy, cmd_done, cmd_status, response_index, response_data,
               if_start_communication, if_command_io, if_check_command_start_bit,
               if_clear_command_crc, if_set_send_command, if_send_command
    );

endinterface

// File: rtl/kfmmc_command_sequencer.sv
// Runs one MMC/SD command: sends the 48-bit CRC7-protected frame, then collects
// and checks a short or long response byte by byte through the bit interface.
module kfmmc_command_sequencer
    import kfmmc_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset_n,
    kfmmc_command_sequencer_if.slave bus
);

    seq_state_t     state_q, state_d;
    logic [5:0]     index_q, index_d;
    logic [31:0]    arg_q, arg_d;
    response_type_t type_q, type_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [135:0]   shift_q, shift_d;
    logic [6:0]     crc_q, crc_d;
    cmd_status_t    status_q, status_d;
    logic [5:0]     rsp_index_q, rsp_index_d;
    logic [127:0]   rsp_data_q, rsp_data_d;
    logic           start_q, start_d;
    logic           io_q, io_d;
    logic           chk_q, chk_d;
    logic           clr_q, clr_d;
    logic           set_q, set_d;
    logic [7:0]     send_q, send_d;

    logic [7:0]     tx_byte;
    logic [7:0]     rx_byte0;
    logic [7:0]     rx_last;
    logic [4:0]     last_idx;

    assign last_idx = last_rx_index(type_q);
    assign rx_byte0 = (type_q == LONG) ? shift_q[135:128] : shift_q[47:40];
    assign rx_last  = shift_q[7:0];

    // The CRC byte is sampled live: TX_LOAD for byte5 is the cycle after byte4 completed.
    always_comb begin
        tx_byte = 8'h00;
        case (cnt_q)
            5'd0:    tx_byte = {2'b01, index_q};
            5'd1:    tx_byte = arg_q[31:24];
            5'd2:    tx_byte = arg_q[23:16];
            5'd3:    tx_byte = arg_q[15:8];
            5'd4:    tx_byte = arg_q[7:0];
            default: tx_byte = {bus.if_send_command_crc, 1'b1};
        endcase
    end

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        arg_d       = arg_q;
        type_d      = type_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        crc_d       = crc_q;
        status_d    = status_q;
        rsp_index_d = rsp_index_q;
        rsp_data_d  = rsp_data_q;
        start_d     = 1'b0;
        io_d        = io_q;
        chk_d       = 1'b0;
        clr_d       = 1'b0;
        set_d       = 1'b0;
        send_d      = send_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_start) begin
                    index_d = bus.cmd_index;
                    arg_d   = bus.cmd_argument;
                    type_d  = response_type_t'(bus.response_type);
                    cnt_d   = 5'd0;
                    clr_d   = 1'b1;
                    state_d = S_TX_LOAD;
                end
            end
            S_TX_LOAD: begin
                start_d = 1'b1;
                set_d   = 1'b1;
                io_d    = 1'b0;
                send_d  = tx_byte;
                state_d = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                if (bus.if_timeout_interrupt) begin
                    status_d = TIMEOUT;
                    state_d  = S_DONE;
                end else if (bus.if_sent_command_interrupt) begin
                    if (cnt_q == 5'(SHORT_BYTES - 1)) begin
                        cnt_d = 5'd0;
                        if (type_q == NONE) begin
                            status_d = OK;
                            state_d  = S_DONE;
                        end else begin
                            state_d = S_RX_ARM;
                        end
                    end else begin
                        cnt_d   = cnt_q + 5'd1;
                        state_d = S_TX_LOAD;
                    end
                end
            end
            S_RX_ARM: begin
                start_d = 1'b1;
                io_d    = 1'b1;
                chk_d   = (cnt_q == 5'd0);
                // R2 CRC covers only bits 127:8, so restart it after the header byte.
                clr_d   = (type_q == LONG) && (cnt_q == 5'd1);
                state_d = S_RX_WAIT;
            end
            S_RX_WAIT: begin
                if (bus.if_timeout_interrupt) begin
                    status_d = TIMEOUT;
                    state_d  = S_DONE;
                end else if (bus.if_received_response_interrupt) begin
                    shift_d = {shift_q[127:0], bus.if_received_response};
                    cnt_d   = cnt_q + 5'd1;
                    if (cnt_q == last_idx - 5'd1)
                        crc_d = bus.if_received_response_crc;
                    state_d = (cnt_q == last_idx) ? S_CHECK : S_RX_ARM;
                end
            end
            S_CHECK: begin
                if (rx_byte0[7] || rx_byte0[6] || !rx_last[0])
                    status_d = FRAME_ERR;
                else if ((type_q == SHORT || type_q == LONG) && (crc_q != rx_last[7:1]))
                    status_d = CRC_ERR;
                else
                    status_d = OK;
                rsp_index_d = rx_byte0[5:0];
                rsp_data_d  = (type_q == LONG) ? shift_q[127:0] : {96'h0, shift_q[39:8]};
                state_d     = S_DONE;
            end
            S_DONE: begin
                io_d    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            index_q     <= '0;
            arg_q       <= '0;
            type_q      <= NONE;
            cnt_q       <= '0;
            shift_q     <= '0;
            crc_q       <= '0;
            status_q    <= OK;
            rsp_index_q <= '0;
            rsp_data_q  <= '0;
            start_q     <= 1'b0;
            io_q        <= 1'b1;
            chk_q       <= 1'b0;
            clr_q       <= 1'b0;
            set_q       <= 1'b0;
            send_q      <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            arg_q       <= arg_d;
            type_q      <= type_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            crc_q       <= crc_d;
            status_q    <= status_d;
            rsp_index_q <= rsp_index_d;
            rsp_data_q  <= rsp_data_d;
            start_q     <= start_d;
            io_q        <= io_d;
            chk_q       <= chk_d;
            clr_q       <= clr_d;
            set_q       <= set_d;
            send_q      <= send_d;
        end
    end

    assign bus.cmd_busy                   = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.cmd_done                   = (state_q == S_DONE);
    assign bus.cmd_status                 = status_q;
    assign bus.response_index             = rsp_index_q;
    assign bus.response_data              = rsp_data_q;
    assign bus.if_start_communication     = start_q;
    assign bus.if_command_io              = io_q;
    assign bus.if_check_command_start_bit = chk_q;
    assign bus.if_clear_command_crc       = clr_q;
    assign bus.if_set_send_command        = set_q;
    assign bus.if_send_command            = send_q;

endmodule

// File: tb/tb_kfmmc_command_sequencer.sv
// Bench for the command sequencer: a behavioural bit-interface/card model plus
// frame-level expectations computed from the MMC command/response rules.
module tb_kfmmc_command_sequencer;
    import kfmmc_pkg::*;

    typedef logic [7:0] byte_q_t[$];

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    kfmmc_command_sequencer_if bus ();

    kfmmc_command_sequencer dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    byte_q_t     tx_log;
    byte_q_t     card_q;
    bit          card_silent;
    int          rx_count;
    logic [5:0]  exp_index;
    logic [127:0] exp_data;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] crc7_byte(input logic [6:0] c, input logic [7:0] b);
        logic [6:0] r;
        logic       fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[6] ^ b[i];
            r  = {r[5:0], 1'b0};
            if (fb) r = r ^ 7'h09;
        end
        return r;
    endfunction

    function automatic logic [6:0] crc7_range(input byte_q_t q, input int first, input int last);
        logic [6:0] c;
        c = 7'h00;
        for (int i = first; i <= last; i++) c = crc7_byte(c, q[i]);
        return c;
    endfunction

    // Expected status straight from the framing/CRC rules of the response.
    function automatic logic [1:0] exp_status(input int typ, input byte_q_t r, input bit silent);
        logic [7:0] b0;
        logic [7:0] lb;
        int         n;
        if (typ == 0) return 2'd0;
        if (silent) return 2'd1;
        n  = r.size();
        b0 = r[0];
        lb = r[n-1];
        if (b0[7] || b0[6] || !lb[0]) return 2'd3;
        if (typ == 1 && crc7_range(r, 0, 4) != lb[7:1]) return 2'd2;
        if (typ == 2 && crc7_range(r, 1, 15) != lb[7:1]) return 2'd2;
        return 2'd0;
    endfunction

    function automatic byte_q_t gen_resp(input int typ, input int kind);
        byte_q_t r;
        logic [7:0] b;
        if (typ == 2) begin
            r.push_back(8'h3F);
            for (int i = 1; i < 16; i++) begin
                b = 8'($urandom);
                r.push_back(b);
            end
            r.push_back({crc7_range(r, 1, 15), 1'b1});
        end else begin
            b = {2'b00, 6'($urandom)};
            r.push_back(b);
            for (int i = 1; i < 5; i++) begin
                b = 8'($urandom);
                r.push_back(b);
            end
            r.push_back({crc7_range(r, 0, 4), 1'b1});
        end
        case (kind)
            1: r[r.size()-1] = r[r.size()-1] ^ 8'h04;
            2: r[r.size()-1] = r[r.size()-1] & 8'hFE;
            3: r[0] = r[0] | (($urandom_range(0, 1) == 1) ? 8'h80 : 8'h40);
            default: ;
        endcase
        return r;
    endfunction

    // Bit-interface and card model, acting on the negedge like the real block.
    initial begin
        int         mode;
        int         remain;
        logic [7:0] cur;
        logic [6:0] tx_crc;
        logic [6:0] rx_crc;
        mode = 0; remain = 0; cur = 8'h00; tx_crc = 7'h00; rx_crc = 7'h00;
        bus.if_received_response           = 8'h00;
        bus.if_send_command_crc            = 7'h00;
        bus.if_received_response_crc       = 7'h00;
        bus.if_sent_command_interrupt      = 1'b0;
        bus.if_received_response_interrupt = 1'b0;
        bus.if_timeout_interrupt           = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                mode = 0; tx_crc = 7'h00; rx_crc = 7'h00;
                bus.if_sent_command_interrupt      = 1'b0;
                bus.if_received_response_interrupt = 1'b0;
                bus.if_timeout_interrupt           = 1'b0;
            end else begin
                if (bus.if_clear_command_crc) begin
                    tx_crc = 7'h00;
                    rx_crc = 7'h00;
                end
                if (bus.if_start_communication) begin
                    bus.if_sent_command_interrupt      = 1'b0;
                    bus.if_received_response_interrupt = 1'b0;
                    bus.if_timeout_interrupt           = 1'b0;
                    if (!bus.if_command_io) begin
                        cur = bus.if_send_command;
                        tx_log.push_back(cur);
                        mode = 1;
                        remain = 2 + $urandom_range(0, 3);
                    end else if (card_silent || card_q.size() == 0) begin
                        mode = 3;
                        remain = 12;
                    end else begin
                        cur = card_q.pop_front();
                        rx_count++;
                        mode = 2;
                        remain = 2 + $urandom_range(0, 3);
                    end
                end else if (mode != 0) begin
                    remain--;
                    if (remain == 0) begin
                        case (mode)
                            1: begin
                                tx_crc = crc7_byte(tx_crc, cur);
                                bus.if_sent_command_interrupt = 1'b1;
                            end
                            2: begin
                                rx_crc = crc7_byte(rx_crc, cur);
                                bus.if_received_response = cur;
                                bus.if_received_response_interrupt = 1'b1;
                            end
                            default: bus.if_timeout_interrupt = 1'b1;
                        endcase
                        mode = 0;
                    end
                end
            end
            bus.if_send_command_crc      = tx_crc;
            bus.if_received_response_crc = rx_crc;
        end
    end

    task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                           input int typ, input byte_q_t resp, input bit silent, input bit poke);
        byte_q_t     eq;
        logic [47:0] exp_tx;
        logic [47:0] got_tx;
        logic [1:0]  est;
        bit          got;
        card_q = resp;
        card_silent = silent;
        tx_log.delete();
        rx_count = 0;
        eq = '{{2'b01, idx}, arg[31:24], arg[23:16], arg[15:8], arg[7:0]};
        exp_tx = {eq[0], eq[1], eq[2], eq[3], eq[4], crc7_range(eq, 0, 4), 1'b1};
        est = exp_status(typ, resp, silent);

        @(negedge clock);
        bus.cmd_index     = idx;
        bus.cmd_argument  = arg;
        bus.response_type = 2'(typ);
        bus.cmd_start     = 1'b1;
        @(posedge clock); #1;
        check_val({tag, " busy_rise"}, bus.cmd_busy, 1);
        @(negedge clock);
        bus.cmd_start = 1'b0;
        if (poke) begin
            repeat (4) @(negedge clock);
            bus.cmd_index     = idx ^ 6'h01;
            bus.response_type = 2'd0;
            bus.cmd_start     = 1'b1;
            @(negedge clock);
            bus.cmd_start     = 1'b0;
        end

        got = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(posedge clock); #1;
            if (bus.cmd_done) got = 1;
        end
        check_val({tag, " done_seen"}, got, 1);
        check_val({tag, " busy_at_done"}, bus.cmd_busy, 0);
        check_val({tag, " status"}, bus.cmd_status, est);
        got_tx = '0;
        for (int i = 0; i < tx_log.size() && i < 6; i++) got_tx = {got_tx[39:0], tx_log[i]};
        check_val({tag, " tx_count"}, tx_log.size(), 6);
        check_val({tag, " tx_frame"}, got_tx, exp_tx);
        check_val({tag, " rx_count"}, rx_count, (typ == 0 || silent) ? 0 : resp.size());
        if (typ != 0 && !silent) begin
            exp_index = resp[0][5:0];
            if (typ == 2) begin
                exp_data = '0;
                for (int i = 1; i <= 16; i++) exp_data = {exp_data[119:0], resp[i]};
            end else begin
                exp_data = {96'h0, resp[1], resp[2], resp[3], resp[4]};
            end
        end
        check_val({tag, " rsp_index"}, bus.response_index, exp_index);
        check_val({tag, " rsp_data"}, bus.response_data, exp_data);
        @(posedge clock); #1;
        check_val({tag, " done_one_cycle"}, bus.cmd_done, 0);
    endtask

    initial begin
        byte_q_t r;
        byte_q_t none_q;
        int      typ;
        int      kind;
        bit      reached;

        bus.cmd_start     = 1'b0;
        bus.cmd_index     = 6'h00;
        bus.cmd_argument  = 32'h0;
        bus.response_type = 2'd0;
        exp_index = '0;
        exp_data  = '0;
        card_silent = 1'b0;
        none_q = {};

        repeat (3) @(negedge clock);
        check_val("rst busy", bus.cmd_busy, 0);
        check_val("rst done", bus.cmd_done, 0);
        check_val("rst status", bus.cmd_status, 0);
        check_val("rst io", bus.if_command_io, 1);
        check_val("rst start", bus.if_start_communication, 0);
        check_val("rst clr", bus.if_clear_command_crc, 0);
        check_val("rst rsp", bus.response_data, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        run_cmd("cmd0", 6'd0, 32'h0, 0, none_q, 1'b0, 1'b0);
        check_val("cmd0 byte5", tx_log[5], 8'h95);

        r = '{8'h08, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h13};
        run_cmd("cmd8", 6'd8, 32'h000001AA, 1, r, 1'b0, 1'b1);
        check_val("cmd8 byte5", tx_log[5], 8'h87);
        check_val("cmd8 status_ok", bus.cmd_status, 0);

        r = '{8'h08, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h15};
        run_cmd("cmd8_badcrc", 6'd8, 32'h000001AA, 1, r, 1'b0, 1'b0);

        r = '{8'h08, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h12};
        run_cmd("cmd8_endbit", 6'd8, 32'h000001AA, 1, r, 1'b0, 1'b0);

        r = gen_resp(2, 0);
        run_cmd("cmd2_r2", 6'd2, 32'h0, 2, r, 1'b0, 1'b0);

        run_cmd("timeout", 6'd13, 32'h12340000, 1, none_q, 1'b1, 1'b0);

        // Abort during TX byte3.
        tx_log.delete();
        card_q = '{8'h08, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h13};
        card_silent = 1'b0;
        @(negedge clock);
        bus.cmd_index = 6'd8; bus.cmd_argument = 32'h1AA; bus.response_type = 2'd1;
        bus.cmd_start = 1'b1;
        @(negedge clock);
        bus.cmd_start = 1'b0;
        reached = 0;
        for (int i = 0; i < 500 && !reached; i++) begin
            @(negedge clock);
            if (tx_log.size() >= 4) reached = 1;
        end
        check_val("rst_mid reached_byte3", reached, 1);
        reset_n = 1'b0;
        #1;
        check_val("rst_mid busy", bus.cmd_busy, 0);
        check_val("rst_mid io", bus.if_command_io, 1);
        check_val("rst_mid done", bus.cmd_done, 0);
        exp_index = '0;
        exp_data  = '0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        r = '{8'h08, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h13};
        run_cmd("after_rst", 6'd8, 32'h000001AA, 1, r, 1'b0, 1'b0);

        for (int n = 0; n < 12; n++) begin
            typ  = $urandom_range(0, 3);
            kind = $urandom_range(0, 4);
            r = gen_resp(typ, (kind == 4) ? 0 : kind);
            run_cmd("rand", 6'($urandom), $urandom, typ, r, kind == 4, n[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/kfmmc_command_sequencer.md
# kfmmc_command_sequencer

Sequences one complete MMC/SD command transaction on top of the byte-level MMC bit interface (KFMMC_Interface). It sits directly upstream of that block and drives its command-side control inputs. It serialises a 6-bit index and 32-bit argument into a 48-bit command frame with CRC7 appended, then collects a 48-bit or 136-bit response byte by byte. It reports response payload, timeout, CRC and framing status to the host-side controller.

## Interface
Parameters:
- none; response lengths are fixed by `response_type`.

Ports:
- `clock`  in  1  system clock; this block uses posedge; the bit interface uses negedge of the same clock
- `reset_n`  in  1  asynchronous, active-low reset
- `cmd_start`  in  1  one-cycle request; ignored while `cmd_busy`=1
- `cmd_index`  in  6  command index, captured at `cmd_start`
- `cmd_argument`  in  32  argument, captured at `cmd_start`
- `response_type`  in  2  0 none, 1 short with CRC (R1/R6/R7), 2 long (R2), 3 short without CRC (R3)
- `cmd_busy`  out  1  transaction in progress
- `cmd_done`  out  1  one-cycle completion pulse
- `cmd_status`  out  2  0 OK, 1 timeout, 2 CRC error, 3 framing error; valid from `cmd_done` until next `cmd_start`
- `response_index`  out  6  byte0[5:0] of the response
- `response_data`  out  128  short: {96'h0, bits 39:8}; long: response bits 127:0
- `if_start_communication`, `if_command_io`, `if_check_command_start_bit`, `if_clear_command_crc`, `if_set_send_command`  out  1 each  bit-interface controls
- `if_send_command`  out  8  byte to transmit
- `if_received_response`  in  8  last received byte, start bit included in byte0
- `if_send_command_crc`, `if_received_response_crc`  in  7  running CRC7 values
- `if_sent_command_interrupt`, `if_received_response_interrupt`, `if_timeout_interrupt`  in  1 each  byte-complete and timeout flags

## Operation
- All `if_*` outputs are registered. Each control is a single-cycle pulse except `if_command_io`, which is a level.
- Transmit frame, MSB first:
  - byte0 = {0,1,index}
  - bytes1–4 = argument[31:0]
  - byte5 = {CRC7,1}, where CRC7 is `if_send_command_crc` captured on the cycle after byte4 completes
- States:
  - IDLE: on `cmd_start`, capture inputs, pulse `if_clear_command_crc`, go to TX_LOAD.
  - TX_LOAD: pulse start+set_send with `if_command_io`=0 and the current byte. Go to TX_WAIT.
  - TX_WAIT: on sent interrupt, increment byte count.
    - After byte5: go to DONE with status 0 if type=0, otherwise go to RX_ARM.
    - Otherwise: go to TX_LOAD.
  - RX_ARM: pulse start with `if_command_io`=1.
    - `if_check_command_start_bit`=1 for byte0, 0 afterwards.
    - For type 2 after byte0, also pulse `if_clear_command_crc`, so the CRC covers bits 127:8 only.
    - Go to RX_WAIT.
  - RX_WAIT: on received interrupt, shift `if_received_response` into a 136-bit shift register and increment the count.
    - Capture `if_received_response_crc` on the interrupt of the second-to-last byte: byte4 for short, byte15 for long.
    - When the last byte arrives (byte5 short, byte16 long), go to CHECK. Otherwise go to RX_ARM.
  - TX_WAIT/RX_WAIT timeout: `if_timeout_interrupt`=1 → DONE with status 1. A timeout takes priority over a simultaneous byte interrupt.
  - CHECK: evaluate in priority order:
    - status 3 if byte0[7]≠0, byte0[6]≠0, or the last bit≠1
    - else status 2 if type∈{1,2} and the captured CRC ≠ last byte[7:1]
    - else status 0
  - DONE: pulse `cmd_done`, deassert `cmd_busy`, go to IDLE.
- Response register updates:
  - `response_data` and `response_index` update only in CHECK.
  - On status 1 they hold their previous values.
- `cmd_start` in a non-IDLE state is dropped, with no queueing.

## Timing
- Reset values:
  - all `if_*` pulses = 0, `if_command_io`=1
  - `cmd_busy`=0, `cmd_done`=0, `cmd_status`=0
  - `response_*`=0
  - state = IDLE, counters = 0
- `cmd_busy` rises the cycle after `cmd_start` and falls in the same cycle as `cmd_done`.
- Interrupt sampling:
  - An interrupt sampled in a WAIT state is acted on that cycle.
  - The start pulse issued in cycle N is taken on the negedge within N, clearing the stale interrupt before posedge N+1.
  - No guard cycle is needed.
- Latency from the last byte interrupt to `cmd_done` is 2 cycles (CHECK, DONE). For type 0, latency after byte5 is 1 cycle.
- `reset_n` asserted mid-transaction aborts immediately with no `cmd_done`. The bit interface is reset by the same system reset.

## Structure
- Shared package `kfmmc_pkg`:
  - `response_type_t` enum: NONE, SHORT, LONG, SHORT_NOCRC
  - `cmd_status_t` enum: OK, TIMEOUT, CRC_ERR, FRAME_ERR
  - sequencer state enum
  - constants SHORT_BYTES=6, LONG_BYTES=17
- Single module, no sub-modules. A top-level wrapper instantiates this block beside KFMMC_Interface.

## Test plan
- CMD0, arg 0, type 0 → transmitted bytes 40 00 00 00 00 95; `cmd_done` with status 0; no receive phase.
- CMD8, arg 0x000001AA, type 1; card model answers 08 00 00 01 AA 13 → transmitted byte5=0x87, status 0, `response_index`=8, `response_data`[31:0]=0x000001AA.
- Same as the previous scenario but the card returns byte5=0x15 → status 2.
- Response byte5 with end bit 0 (0x12) → status 3.
- CMD2, type 2; card returns a 17-byte R2 with valid CRC over bytes1–15 → status 0, `response_data`=bytes1–16.
- Card never drives a start bit, with the timeout model firing → status 1, `response_data` unchanged.
- `reset_n` low during TX byte3 → `cmd_busy`=0 and `if_command_io`=1 immediately; a new `cmd_start` afterwards completes normally.
